// File: rtl/test_port_pkg.sv
// Shared constants, state encoding and byte-order helper for the
// test-report port writer.
package test_port_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] TEST_PORT    = 30'h3FF;
    localparam logic [DATA_W-1:0] BEGIN_SYMBOL = 32'h00000168;
    localparam logic [DATA_W-1:0] END_SYMBOL   = 32'hFFFFFD5D;

    typedef enum logic [2:0] {
        IDLE,
        WR_BEGIN,
        GAP,
        WAIT_DATA,
        WR_DATA,
        WR_END,
        DONE
    } state_t;

    // Readable word -> little-endian bus order.
    function automatic logic [DATA_W-1:0] bswap(
        input logic [DATA_W-1:0] w
    );
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/test_port_writer_if.sv
// Data-memory write bus between the report writer and the
// cache/test-port side.
interface test_port_writer_if;
    import test_port_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic              mem_stall;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wen,
        input  mem_stall
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wen,
        output mem_stall
    );

endinterface

// File: rtl/test_port_writer_fifo.sv
// Synchronous result FIFO with registered full/empty flags and a
// show-ahead head word.
module result_fifo
    import test_port_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_n;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from last cycle's count, so a pop never frees a
    // slot for a push in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_n = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_n = count + ONE_CNT;
            2'b01:   count_n = count - ONE_CNT;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ONE_PTR;
            if (pop_ok)  rd_ptr <= rd_ptr + ONE_PTR;
            count <= count_n;
            full  <= (count_n == FULL_CNT);
            empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/test_port_writer.sv
// Streams BEGIN, NUM_WORDS buffered results and END as word writes
// to the test port, one idle bus cycle between writes.
module test_port_writer
    import test_port_pkg::*;
#(
    parameter int NUM_WORDS  = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               res_valid,
    input  logic [DATA_W-1:0]  res_data,
    output logic               res_ready,
    test_port_writer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic [3:0]         sent_cnt
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_WORDS + 1);

    state_t            state;
    state_t            state_n;
    logic              wen_q;
    logic              wen_n;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_n;
    logic              busy_n;
    logic              done_n;
    logic [3:0]        cnt_n;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_valid),
        .pop   (fifo_pop),
        .wdata (res_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign res_ready     = !fifo_full;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    always_comb begin
        state_n  = state;
        wen_n    = wen_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        busy_n   = busy;
        done_n   = done;
        cnt_n    = sent_cnt;
        fifo_pop = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = WR_BEGIN;
                    wen_n   = 1'b1;
                    addr_n  = TEST_PORT;
                    wdata_n = bswap(BEGIN_SYMBOL);
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    cnt_n   = '0;
                end
            end
            WR_BEGIN, WR_DATA: begin
                if (!bus.mem_stall) begin
                    state_n = GAP;
                    wen_n   = 1'b0;
                    addr_n  = '0;
                    cnt_n   = sent_cnt + 4'd1;
                end
            end
            WR_END: begin
                if (!bus.mem_stall) begin
                    state_n = DONE;
                    wen_n   = 1'b0;
                    addr_n  = '0;
                    cnt_n   = sent_cnt + 4'd1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            GAP: begin
                // sent_cnt includes BEGIN, hence the +1 in LAST_CNT.
                if (sent_cnt == LAST_CNT) begin
                    state_n = WR_END;
                    wen_n   = 1'b1;
                    addr_n  = TEST_PORT;
                    wdata_n = bswap(END_SYMBOL);
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_n  = WR_DATA;
                    wen_n    = 1'b1;
                    addr_n   = TEST_PORT;
                    wdata_n  = bswap(fifo_head);
                end else begin
                    state_n = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_n  = WR_DATA;
                    wen_n    = 1'b1;
                    addr_n   = TEST_PORT;
                    wdata_n  = bswap(fifo_head);
                end
            end
            default: begin
                state_n = IDLE;
                wen_n   = 1'b0;
                addr_n  = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sent_cnt <= '0;
        end else begin
            state    <= state_n;
            wen_q    <= wen_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            busy     <= busy_n;
            done     <= done_n;
            sent_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_test_port_writer.sv
// Directed bench for test_port_writer: framing, stalls, empty FIFO,
// back-pressure, mid-frame reset and start handling.
module tb_test_port_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic [3:0]  sent_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_data [12];
    logic [31:0] push_q [$];

    logic [31:0] t1 [12] = '{
        32'd0, 32'd1, 32'd1, 32'd2, 32'd1, 32'd2,
        32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd0
    };
    logic [31:0] e1 [12] = '{
        32'h00000000, 32'h01000000, 32'h01000000,
        32'h02000000, 32'h01000000, 32'h02000000,
        32'h02000000, 32'h02000000, 32'h01000000,
        32'h01000000, 32'h01000000, 32'h00000000
    };

    test_port_writer_if bus_if ();

    always #5 clk = ~clk;

    test_port_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .bus       (bus_if),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int idx);
        if (idx == 0)  return 32'h68010000;
        if (idx == 13) return 32'h5DFDFFFF;
        if (idx >= 1 && idx <= 12) return exp_data[idx-1];
        return 32'hDEADBEEF;
    endfunction

    // Watches completed writes until done, feeding push_q meanwhile.
    task automatic run_frame(input int first, input bit timed);
        int idx = first;
        int cyc = 1;
        bit acc;
        while (!done && cyc < 100) begin
            res_valid = (push_q.size() > 0);
            if (push_q.size() > 0) res_data = push_q[0];
            acc = res_valid && res_ready;
            if (bus_if.mem_wen && !bus_if.mem_stall) begin
                chk("addr", 32'(bus_if.mem_addr), 32'h3FF);
                chk("wdata", bus_if.mem_wdata, exp_word(idx));
                if (timed) chk("wr_cyc", cyc, 2 * idx + 1);
                idx++;
            end
            step();
            cyc++;
            if (acc) void'(push_q.pop_front());
        end
        res_valid = 1'b0;
        chk("done", 32'(done), 1);
        chk("sent_cnt", 32'(sent_cnt), 14);
        chk("n_writes", idx, 14);
        if (timed) chk("done_cyc", cyc, 28);
    endtask

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        res_valid        = 1'b0;
        res_data         = '0;
        bus_if.mem_stall = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_wen", 32'(bus_if.mem_wen), 0);
        chk("rst_addr", 32'(bus_if.mem_addr), 0);
        chk("rst_wdata", bus_if.mem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(sent_cnt), 0);
        chk("rst_ready", 32'(res_ready), 1);

        // Prefilled frame, no stalls
        for (int i = 0; i < 12; i++) begin
            res_valid   = 1'b1;
            res_data    = t1[i];
            exp_data[i] = e1[i];
            step();
        end
        res_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame(0, 1'b1);

        // Third write stalled for three cycles
        for (int i = 0; i < 12; i++) begin
            res_valid   = 1'b1;
            res_data    = {24'h112233, 8'(i)};
            exp_data[i] = {8'(i), 24'h332211};
            step();
        end
        res_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("st_wen0", 32'(bus_if.mem_wen), 1);
        chk("st_data0", bus_if.mem_wdata, 32'h01332211);
        bus_if.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_wen", 32'(bus_if.mem_wen), 1);
            chk("st_addr", 32'(bus_if.mem_addr), 32'h3FF);
            chk("st_data", bus_if.mem_wdata, 32'h01332211);
            chk("st_cnt", 32'(sent_cnt), 2);
        end
        bus_if.mem_stall = 1'b0;
        step();
        chk("st_gap", 32'(bus_if.mem_wen), 0);
        chk("st_cnt3", 32'(sent_cnt), 3);
        step();
        run_frame(3, 1'b0);

        // Start with an empty FIFO
        start = 1'b1;
        step();
        start = 1'b0;
        chk("em_begin", bus_if.mem_wdata, 32'h68010000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("em_idle", 32'(bus_if.mem_wen), 0);
        end
        res_valid = 1'b1;
        res_data  = 32'd5;
        step();
        res_valid = 1'b0;
        chk("em_pop", 32'(bus_if.mem_wen), 0);
        step();
        chk("em_wen", 32'(bus_if.mem_wen), 1);
        chk("em_data", bus_if.mem_wdata, 32'h05000000);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Fill to full, 17th word held by the producer
        for (int k = 1; k <= 16; k++) begin
            res_valid = 1'b1;
            res_data  = 32'h100 + k;
            if (k <= 12) exp_data[k-1] = {8'(k), 8'h01, 16'h0000};
            step();
        end
        chk("full_ready", 32'(res_ready), 0);
        res_data = 32'h111;
        step();
        chk("held_ready", 32'(res_ready), 0);
        chk("held_busy", 32'(busy), 0);
        push_q.push_back(32'h111);
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame(0, 1'b1);

        // Reset during a stalled fifth write
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("r5_wen", 32'(bus_if.mem_wen), 1);
        chk("r5_data", bus_if.mem_wdata, 32'h10010000);
        chk("r5_cnt", 32'(sent_cnt), 4);
        bus_if.mem_stall = 1'b1;
        step();
        chk("r5_hold", 32'(bus_if.mem_wen), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.mem_stall = 1'b0;
        chk("r5_wen_rst", 32'(bus_if.mem_wen), 0);
        chk("r5_addr_rst", 32'(bus_if.mem_addr), 0);
        chk("r5_busy_rst", 32'(busy), 0);
        chk("r5_cnt_rst", 32'(sent_cnt), 0);
        chk("r5_ready_rst", 32'(res_ready), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("r5_begin", bus_if.mem_wdata, 32'h68010000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r5_flushed", 32'(bus_if.mem_wen), 0);
        end

        // Start while busy is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_wen", 32'(bus_if.mem_wen), 0);
        chk("ign_cnt", 32'(sent_cnt), 1);
        chk("ign_busy", 32'(busy), 1);
        for (int i = 0; i < 12; i++) begin
            push_q.push_back(t1[i]);
            exp_data[i] = e1[i];
        end
        run_frame(1, 1'b0);

        // Start from DONE
        start = 1'b1;
        step();
        start = 1'b0;
        chk("re_done", 32'(done), 0);
        chk("re_busy", 32'(busy), 1);
        chk("re_wen", 32'(bus_if.mem_wen), 1);
        chk("re_data", bus_if.mem_wdata, 32'h68010000);
        chk("re_cnt", 32'(sent_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
